// File: rtl/sort_hw_instr_loader.sv
// Boot image loader: packs a byte stream little-endian into 32-bit words and writes them to instruction RAM.
// Latency: a word is written one cycle after its 4th byte (or s_last byte) is accepted; done follows one cycle after the final write.
// Backpressure: s_ready is high only in LOAD, so each word costs one stall cycle; no bytes are taken once done or overflowed.
module sort_hw_instr_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [3:0]        ram_byteenable,
    output logic [31:0]       ram_writedata,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   words_written,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_hold_q;
    logic [31:0]       buf_q, data_hold_q, sum_q, wr_data;
    logic [3:0]        mask_q;
    logic [1:0]        lane_q;
    logic              last_q, full_q, err_q;
    logic [ADDR_W:0]   words_q;
    logic              hs, word_end, start_ok;

    assign hs       = s_valid && s_ready;
    assign word_end = hs && ((lane_q == 2'd3) || s_last);
    assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign wr_data  = buf_q & {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_LOAD;
            // full_q means LAST_ADDR is already written: a further word overflows instead of wrapping
            S_LOAD:         if (word_end) state_d = full_q ? S_DONE : S_WRITE;
            S_WRITE:        state_d = last_q ? S_DONE : S_LOAD;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            addr_hold_q <= '0;
            buf_q       <= '0;
            data_hold_q <= '0;
            mask_q      <= '0;
            lane_q      <= '0;
            last_q      <= 1'b0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            words_q     <= '0;
            sum_q       <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                addr_q  <= base_addr;
                buf_q   <= '0;
                mask_q  <= '0;
                lane_q  <= '0;
                last_q  <= 1'b0;
                full_q  <= 1'b0;
                err_q   <= 1'b0;
                words_q <= '0;
                sum_q   <= '0;
            end else if (state_q == S_LOAD) begin
                if (hs) begin
                    buf_q[{lane_q, 3'b000} +: 8] <= s_data;
                    mask_q[lane_q]               <= 1'b1;
                    lane_q                       <= lane_q + 2'd1;
                    if (s_last) last_q <= 1'b1;
                end
                if (word_end && full_q) err_q <= 1'b1;
            end else if (state_q == S_WRITE) begin
                sum_q       <= sum_q + wr_data;
                words_q     <= words_q + 1'b1;
                addr_hold_q <= addr_q;
                data_hold_q <= wr_data;
                buf_q       <= '0;
                mask_q      <= '0;
                lane_q      <= '0;
                if (addr_q == LAST_ADDR) full_q <= 1'b1;
                else                     addr_q <= addr_q + 1'b1;
            end
        end
    end

    always_comb begin
        s_ready        = (state_q == S_LOAD);
        busy           = (state_q == S_LOAD) || (state_q == S_WRITE);
        done           = (state_q == S_DONE);
        ram_chipselect = (state_q == S_WRITE);
        ram_write      = (state_q == S_WRITE);
        ram_byteenable = (state_q == S_WRITE) ? mask_q  : 4'b0000;
        ram_address    = (state_q == S_WRITE) ? addr_q  : addr_hold_q;
        ram_writedata  = (state_q == S_WRITE) ? wr_data : data_hold_q;
        err_overflow   = err_q;
        words_written  = words_q;
        checksum       = sum_q;
    end

endmodule

// File: tb/tb_sort_hw_instr_loader.sv
// Bench for sort_hw_instr_loader: vector table of load images plus reset and latency sequences.
module tb_sort_hw_instr_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [7:0]        s_data = 8'h00;
    logic              s_last = 1'b0;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect, ram_write;
    logic [3:0]        ram_byteenable;
    logic [31:0]       ram_writedata;
    logic              busy, done, err_overflow;
    logic [ADDR_W:0]   words_written;
    logic [31:0]       checksum;

    sort_hw_instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
        .busy(busy), .done(done), .err_overflow(err_overflow),
        .words_written(words_written), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                nbytes;
        logic [127:0]      bytes;
        bit                gap;
        bit                mid_start;
        logic [ADDR_W:0]   exp_words;
        logic [31:0]       exp_sum;
        bit                exp_err;
    } vec_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } wr_t;

    wr_t  exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   wr_seen = 0;
    int   exp_total = 0;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every RAM write must match the oldest word the bench has completed.
    always @(negedge clk) begin
        if (reset_n && (ram_chipselect || ram_write)) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(exp_q.size()), 64'd1);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", 64'(ram_address), 64'(w.addr));
                check("wr_data", 64'(ram_writedata), 64'(w.data));
                check("wr_be", 64'(ram_byteenable), 64'(w.be));
                check("wr_strobe", 64'({ram_chipselect, ram_write}), 64'd3);
            end
        end
    end

    task automatic wait_hs(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = s_ready;
        if (!ok) check("hs_timeout", 64'(s_ready), 64'd1);
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] addr);
        base_addr = addr;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int          addr_m;
        int          lane;
        logic [31:0] word;
        logic [3:0]  be;
        bit          ovf, ok;
        logic [7:0]  b;
        addr_m = int'(v.base);
        lane = 0;
        word = '0;
        be = '0;
        ovf = 1'b0;
        pulse_start(v.base);
        check("start_clear", 64'({busy, s_ready, done, err_overflow, words_written}), 64'({2'b11, 2'b00, 11'd0}));
        check("start_sum", 64'(checksum), 64'd0);
        for (int i = 0; i < v.nbytes; i++) begin
            if (v.gap && i > 0) begin
                s_valid = 1'b0;
                s_data = 8'hEE;
                s_last = 1'b1;
                repeat (2) @(posedge clk);
                #1;
            end
            if (v.mid_start && i == 2) begin
                pulse_start(ADDR_W'(77));
                base_addr = v.base;
            end
            b = v.bytes[i*8 +: 8];
            s_valid = 1'b1;
            s_data = b;
            s_last = (i == v.nbytes - 1);
            wait_hs(ok);
            s_valid = 1'b0;
            s_last = 1'b0;
            if (!ok) return;
            word[lane*8 +: 8] = b;
            be[lane] = 1'b1;
            lane++;
            if (lane == 4 || i == v.nbytes - 1) begin
                if (addr_m <= DEPTH - 1) begin
                    exp_q.push_back('{ADDR_W'(addr_m), word, be});
                    exp_total++;
                    addr_m++;
                    check("wr_latency", 64'(ram_write), 64'd1);
                end else begin
                    ovf = 1'b1;
                    check("ovf_suppress", 64'({ram_chipselect, ram_write}), 64'd0);
                    check("ovf_flag_done", 64'({err_overflow, done}), 64'd3);
                end
                word = '0;
                be = '0;
                lane = 0;
            end
            if (ovf) break;
        end
        if (!ovf) begin
            check("done_not_early", 64'(done), 64'd0);
            @(posedge clk);
            #1;
            check("done_rise", 64'(done), 64'd1);
        end
        s_valid = 1'b1;
        s_data = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            check("ready_low_after", 64'(s_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("words", 64'(words_written), 64'(v.exp_words));
        check("checksum", 64'(checksum), 64'(v.exp_sum));
        check("err", 64'(err_overflow), 64'(v.exp_err));
        check("end_flags", 64'({done, busy}), 64'd2);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vecs[0] = '{base: 10'd0,    nbytes: 8,  bytes: 128'h08070605_04030201, gap: 0, mid_start: 0,
                    exp_words: 11'd2, exp_sum: 32'h0C0A0806, exp_err: 0};
        vecs[1] = '{base: 10'd5,    nbytes: 5,  bytes: 128'h55_44332211, gap: 0, mid_start: 1,
                    exp_words: 11'd2, exp_sum: 32'h44332266, exp_err: 0};
        vecs[2] = '{base: 10'd1022, nbytes: 12, bytes: 128'h0C0B0A09_08070605_04030201, gap: 0, mid_start: 0,
                    exp_words: 11'd2, exp_sum: 32'h0C0A0806, exp_err: 1};
        vecs[3] = '{base: 10'd0,    nbytes: 8,  bytes: 128'h08070605_04030201, gap: 1, mid_start: 0,
                    exp_words: 11'd2, exp_sum: 32'h0C0A0806, exp_err: 0};
        vecs[4] = '{base: 10'd1023, nbytes: 4,  bytes: 128'hD4C3B2A1, gap: 0, mid_start: 0,
                    exp_words: 11'd1, exp_sum: 32'hD4C3B2A1, exp_err: 0};

        #1 reset_n = 1'b0;
        #2;
        check("reset_ctrl", 64'({s_ready, busy, done, err_overflow, ram_chipselect, ram_write,
                                 ram_byteenable, ram_address, words_written}), 64'd0);
        check("reset_data", {checksum, ram_writedata}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // Reset in the middle of the second word: the partial word must never be written.
        pulse_start(10'd300);
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data = 8'hA0 + 8'(i);
            s_last = 1'b0;
            wait_hs(ok);
            s_valid = 1'b0;
            if (i == 3) begin
                exp_q.push_back('{10'd300, 32'hA3A2A1A0, 4'hF});
                exp_total++;
            end
        end
        @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_ctrl", 64'({s_ready, busy, done, err_overflow, ram_chipselect, ram_write,
                                   ram_byteenable, ram_address, words_written}), 64'd0);
        check("rst_mid_data", {checksum, ram_writedata}, 64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        s_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_after_rst", 64'({busy, s_ready, done}), 64'd0);
        s_valid = 1'b0;
        check("total_writes", 64'(wr_seen), 64'(exp_total));
        check("sb_final", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sort_hw_instr_loader.md
Name: sort_hw_instr_loader

Overview:
- Boot-time image loader that sits directly upstream of the 1024x32 single-port instruction on-chip RAM.
- Accepts a byte stream from a UART or JTAG bridge and packs it little-endian into 32-bit words.
- Writes each word into the RAM slave through its chipselect/write/byteenable port.
- Reports word count, a 32-bit additive checksum and an overflow error to the host-side control logic.

Parameters:
- ADDR_W, 10, RAM word-address width.
- DEPTH, 1024, number of RAM words; the highest legal address is DEPTH-1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first RAM word address; latched on start.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  stream byte accepted when s_valid&s_ready.
- s_data  in  8  stream byte.
- s_last  in  1  marks the final byte of the image.
- ram_address  out  ADDR_W  RAM word address.
- ram_chipselect  out  1  RAM select.
- ram_write  out  1  RAM write strobe.
- ram_byteenable  out  4  lanes being written.
- ram_writedata  out  32  packed word.
- busy  out  1  high in LOAD or WRITE.
- done  out  1  level; set on completion, cleared by the next accepted start.
- err_overflow  out  1  level; the image exceeded the RAM; cleared by the next accepted start.
- words_written  out  ADDR_W+1  count of RAM writes issued in this load.
- checksum  out  32  sum mod 2^32 of all written words; disabled lanes count as 0.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; the partial word, lane index and address counter are cleared. Reset mid-load abandons the load with no further RAM writes.
- IDLE:
  - s_ready=0.
  - When start=1: latch base_addr into the address counter, clear words_written, checksum, done and err_overflow, then go to LOAD.
- LOAD:
  - s_ready=1.
  - On each handshake, store s_data into lane lane_idx of the word buffer, set the matching bit of the lane mask, then increment lane_idx (2-bit, wraps).
  - If lane_idx was 3, or s_last=1, go to WRITE on the next cycle.
- WRITE (exactly one cycle):
  - s_ready=0; ram_chipselect=ram_write=1.
  - ram_address=counter; ram_byteenable=lane mask; ram_writedata=buffer, with disabled lanes driven 0.
  - Same cycle, registered on the edge: checksum += writedata; words_written += 1; counter += 1; buffer, mask and lane_idx cleared.
  - Next state is DONE if this word held s_last, otherwise LOAD.
- Overflow: a new word needs writing, i.e. the transition to WRITE, while the counter has already written address DEPTH-1.
  - That WRITE cycle is suppressed: chipselect and write stay 0, counters are unchanged.
  - err_overflow is set to 1 and the state goes to DONE.
  - Remaining stream bytes are not accepted; s_ready=0.
  - No address wrap-around under any condition.
- DONE: done=1; behaves as IDLE, so a new start restarts the load.
- start while busy is ignored.
- ram_chipselect, ram_write and ram_byteenable are 0 outside WRITE. ram_address and ram_writedata hold their last values.
- Timing:
  - The first RAM write occurs 1 cycle after the 4th byte handshake.
  - Sustained throughput is 4 bytes per 5 cycles.
  - done rises 1 cycle after the final WRITE.
- Stream rules:
  - s_valid gaps are legal at any point.
  - s_data and s_last are ignored without a handshake.

Test Plan:
- base_addr=0, bytes 01..08, last on 08 -> writes at addr 0 data 0x04030201 be 0xF and addr 1 data 0x08070605 be 0xF; words_written=2; checksum=0x0C0A0806; done=1.
- base_addr=5, bytes 11,22,33,44,55 last -> addr 5 0x44332211 be 0xF, then addr 6 0x00000055 be 0x1; words_written=2.
- base_addr=1022, 12 bytes -> writes at 1022 and 1023 only, then err_overflow=1 and done=1; s_ready=0 for the remaining bytes; no write at 1024 or 0.
- s_valid toggled 1-0-0-1 per cycle over 8 bytes -> identical RAM writes to the first scenario; no write issued before the 4th byte is accepted.
- start pulsed again mid-load -> ignored; the load completes unchanged. start after done -> counters and flags cleared, and a new load runs at the new base_addr.
- reset_n asserted after 6 of 8 bytes -> all outputs 0 immediately; the pending partial word is never written; IDLE after release.
